// File: rtl/vc_xbar_pkg.sv
// Shared definitions for the 3-in/3-out crossbar allocator.
//   c_xbar_nports       number of inputs and outputs
//   c_xbar_idx_nbits    width of a port index / crossbar select
//   c_xbar_dest_invalid destination code that never matches an output
//   rr_next(idx)        round-robin successor, (idx + 1) mod 3
package vc_xbar_pkg;

    localparam int unsigned c_xbar_nports    = 3;
    localparam int unsigned c_xbar_idx_nbits = 2;

    typedef logic [c_xbar_idx_nbits-1:0] xbar_idx_t;

    localparam xbar_idx_t c_xbar_dest_invalid = 2'd3;

    function automatic xbar_idx_t rr_next(input xbar_idx_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/vc_xbar_out_arb.sv
// Per-output arbiter: round-robin among requesting inputs, with a packet lock that
// pins the output to one input from the first flit to the tail flit.
//   clk, reset  clock and synchronous active-high reset
//   req         bit i: input i requests this output
//   tail        bit i: flit on input i is a tail flit
//   out_rdy     downstream of this output accepts
//   grant       one-hot granted input (zero when no grant)
//   sel         index of the granted input, 0 when no grant
//   out_val     a grant is present
module vc_xbar_out_arb
    import vc_xbar_pkg::*;
#(
    parameter bit        p_lock_en   = 1'b1,
    parameter xbar_idx_t p_init_prio = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] tail,
    input  logic       out_rdy,
    output logic [2:0] grant,
    output xbar_idx_t  sel,
    output logic       out_val
);

    logic      lock_q, lock_d;
    xbar_idx_t owner_q, owner_d;
    xbar_idx_t prio_q, prio_d;

    xbar_idx_t scan_idx;
    logic      found;
    logic      tail_g;
    logic      fire;

    // Grant selection
    always_comb begin
        grant    = 3'b000;
        sel      = 2'd0;
        out_val  = 1'b0;
        found    = 1'b0;
        scan_idx = prio_q;
        if (!reset) begin
            if (lock_q) begin
                // Locked: only the owner may proceed, others wait even if it idles.
                for (int i = 0; i < 3; i++) begin
                    if (owner_q == i[1:0] && req[i]) begin
                        grant[i] = 1'b1;
                        sel      = i[1:0];
                        out_val  = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    for (int i = 0; i < 3; i++) begin
                        if (!found && scan_idx == i[1:0] && req[i]) begin
                            found    = 1'b1;
                            grant[i] = 1'b1;
                            sel      = i[1:0];
                            out_val  = 1'b1;
                        end
                    end
                    scan_idx = rr_next(scan_idx);
                end
            end
        end
    end

    // Lock / priority update on a fire
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        tail_g  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                tail_g = tail[i];
            end
        end
        fire = out_val && out_rdy;
        if (fire) begin
            if (tail_g || !p_lock_en) begin
                lock_d = 1'b0;
                prio_d = rr_next(sel);
            end else begin
                lock_d  = 1'b1;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= 2'd0;
            prio_q  <= p_init_prio;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: rtl/vc_crossbar3_alloc_ctrl.sv
// Switch allocator for a 3-in/3-out mux crossbar. Decodes per-input destinations
// into per-output requests, runs one arbiter per output, and drives the crossbar
// selects and the val/rdy handshakes. Transfers happen in the cycle of the grant.
//   clk, reset  clock and synchronous active-high reset
//   in_val      bit i: input i holds a valid flit
//   in_dest     [2i+1:2i] destination of input i (3 = invalid)
//   in_tail     bit i: flit on input i ends its packet
//   in_rdy      bit i: input i's flit transfers this cycle
//   out_val     bit o: output o carries a valid flit
//   out_rdy     bit o: downstream of output o accepts
//   sel0..sel2  crossbar selects (granted input index, 0 when idle)
//   bad_dest    registered pulse: a valid input had an invalid destination last cycle
module vc_crossbar3_alloc_ctrl
    import vc_xbar_pkg::*;
#(
    parameter bit          p_lock_en   = 1'b1,
    parameter int unsigned p_init_prio = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_val,
    input  logic [5:0] in_dest,
    input  logic [2:0] in_tail,
    output logic [2:0] in_rdy,
    output logic [2:0] out_val,
    input  logic [2:0] out_rdy,
    output logic [1:0] sel0,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic       bad_dest
);

    localparam xbar_idx_t InitPrio = xbar_idx_t'(p_init_prio);

    logic [2:0] req   [c_xbar_nports];
    logic [2:0] grant [c_xbar_nports];
    xbar_idx_t  sel   [c_xbar_nports];

    logic bad_dest_q, bad_dest_d;

    // Each input requests at most one output, so no input-side conflict exists.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            req[o] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                req[o][i] = in_val[i] && (in_dest[2*i +: 2] == o[1:0]);
            end
        end
    end

    for (genvar g = 0; g < c_xbar_nports; g++) begin : g_out
        vc_xbar_out_arb #(
            .p_lock_en   (p_lock_en),
            .p_init_prio (InitPrio)
        ) u_arb (
            .clk     (clk),
            .reset   (reset),
            .req     (req[g]),
            .tail    (in_tail),
            .out_rdy (out_rdy[g]),
            .grant   (grant[g]),
            .sel     (sel[g]),
            .out_val (out_val[g])
        );
    end

    always_comb begin
        in_rdy = 3'b000;
        for (int i = 0; i < 3; i++) begin
            for (int o = 0; o < 3; o++) begin
                if (grant[o][i] && out_rdy[o]) begin
                    in_rdy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bad_dest_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in_val[i] && in_dest[2*i +: 2] == c_xbar_dest_invalid) begin
                bad_dest_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_dest_q <= 1'b0;
        end else begin
            bad_dest_q <= bad_dest_d;
        end
    end

    assign sel0     = sel[0];
    assign sel1     = sel[1];
    assign sel2     = sel[2];
    assign bad_dest = bad_dest_q;

endmodule

// File: tb/tb_vc_crossbar3_alloc_ctrl.sv
module tb_vc_crossbar3_alloc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in_val = 3'b000;
    logic [5:0] in_dest = 6'd0;
    logic [2:0] in_tail = 3'b000;
    logic [2:0] in_rdy;
    logic [2:0] out_val;
    logic [2:0] out_rdy = 3'b000;
    logic [1:0] sel0, sel1, sel2;
    logic       bad_dest;

    int checks = 0;
    int errors = 0;
    bit stim_done = 1'b0;

    typedef struct {
        logic [2:0] oval;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [2:0] irdy;
        logic       bad;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    vc_crossbar3_alloc_ctrl #(
        .p_lock_en   (1'b1),
        .p_init_prio (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_dest  (in_dest),
        .in_tail  (in_tail),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .sel0     (sel0),
        .sel1     (sel1),
        .sel2     (sel2),
        .bad_dest (bad_dest)
    );

    function automatic logic [5:0] dst(input logic [1:0] d2, input logic [1:0] d1,
                                       input logic [1:0] d0);
        return {d2, d1, d0};
    endfunction

    task automatic chk(input string nm, input string field, input logic [2:0] act,
                       input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b", nm, field, act, req);
        end
    endtask

    // One cycle of stimulus; the expected combinational/registered view is queued.
    task automatic step(input logic rst, input logic [2:0] val, input logic [5:0] dest,
                        input logic [2:0] tail, input logic [2:0] ordy,
                        input logic [2:0] e_oval, input logic [1:0] e_s0,
                        input logic [1:0] e_s1, input logic [1:0] e_s2,
                        input logic [2:0] e_irdy, input logic e_bad, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rst;
        in_val  = val;
        in_dest = dest;
        in_tail = tail;
        out_rdy = ordy;
        e.oval = e_oval;
        e.s0   = e_s0;
        e.s1   = e_s1;
        e.s2   = e_s2;
        e.irdy = e_irdy;
        e.bad  = e_bad;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every cycle for which an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "out_val", out_val, e.oval);
                chk(e.name, "sel0", {1'b0, sel0}, {1'b0, e.s0});
                chk(e.name, "sel1", {1'b0, sel1}, {1'b0, e.s1});
                chk(e.name, "sel2", {1'b0, sel2}, {1'b0, e.s2});
                chk(e.name, "in_rdy", in_rdy, e.irdy);
                chk(e.name, "bad_dest", {2'b00, bad_dest}, {2'b00, e.bad});
            end
        end
    end

    initial begin
        // Reset, including requests that must be suppressed while reset is high.
        step(1, 3'b000, dst(0, 0, 0), 3'b000, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "rst_idle");
        step(1, 3'b111, dst(2, 1, 0), 3'b111, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "rst_req");

        // 1: single flit in0 -> out1, prio1 becomes 1.
        step(0, 3'b001, dst(0, 0, 1), 3'b001, 3'b111, 3'b010, 0, 0, 0, 3'b001, 0, "t1_first");
        step(0, 3'b011, dst(0, 1, 1), 3'b011, 3'b111, 3'b010, 0, 1, 0, 3'b010, 0, "t1_prio1");
        step(0, 3'b011, dst(0, 1, 1), 3'b011, 3'b111, 3'b010, 0, 0, 0, 3'b001, 0, "t1_prio2");

        // 2: round-robin at out2.
        step(0, 3'b111, dst(2, 2, 2), 3'b111, 3'b111, 3'b100, 0, 0, 0, 3'b001, 0, "t2_rr0");
        step(0, 3'b111, dst(2, 2, 2), 3'b111, 3'b111, 3'b100, 0, 0, 1, 3'b010, 0, "t2_rr1");
        step(0, 3'b111, dst(2, 2, 2), 3'b111, 3'b111, 3'b100, 0, 0, 2, 3'b100, 0, "t2_rr2");
        step(0, 3'b111, dst(2, 2, 2), 3'b111, 3'b111, 3'b100, 0, 0, 0, 3'b001, 0, "t2_rr3");

        // 3: 3-flit packet in0 -> out0, in1 contends and stays blocked.
        step(0, 3'b011, dst(0, 0, 0), 3'b010, 3'b111, 3'b001, 0, 0, 0, 3'b001, 0, "t3_head");
        step(0, 3'b010, dst(0, 0, 0), 3'b010, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "t3_ownidle");
        step(0, 3'b011, dst(0, 0, 0), 3'b010, 3'b111, 3'b001, 0, 0, 0, 3'b001, 0, "t3_body");
        step(0, 3'b011, dst(0, 0, 0), 3'b011, 3'b111, 3'b001, 0, 0, 0, 3'b001, 0, "t3_tail");
        step(0, 3'b010, dst(0, 0, 0), 3'b010, 3'b111, 3'b001, 1, 0, 0, 3'b010, 0, "t3_in1");

        // 4: stall on out1, then a single fire rotates prio1 to 0.
        for (int k = 0; k < 4; k++) begin
            step(0, 3'b100, dst(1, 0, 0), 3'b100, 3'b101, 3'b010, 0, 2, 0, 3'b000, 0,
                 "t4_stall");
        end
        step(0, 3'b100, dst(1, 0, 0), 3'b100, 3'b111, 3'b010, 0, 2, 0, 3'b100, 0, "t4_fire");
        step(0, 3'b111, dst(1, 1, 1), 3'b111, 3'b111, 3'b010, 0, 0, 0, 3'b001, 0, "t4_prio");

        // 5: invalid dest on in0 alongside two parallel transfers.
        step(0, 3'b111, dst(1, 0, 3), 3'b111, 3'b111, 3'b011, 1, 2, 0, 3'b110, 0, "t5_par");
        step(0, 3'b000, dst(0, 0, 0), 3'b000, 3'b111, 3'b000, 0, 0, 0, 3'b000, 1, "t5_bad");
        step(0, 3'b000, dst(0, 0, 0), 3'b000, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "t5_clr");

        // 6: reset while out0 is locked to in1.
        step(0, 3'b010, dst(0, 0, 0), 3'b000, 3'b111, 3'b001, 1, 0, 0, 3'b010, 0, "t6_lock");
        step(0, 3'b100, dst(0, 0, 0), 3'b100, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "t6_block");
        step(1, 3'b100, dst(0, 0, 0), 3'b100, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "t6_rst");
        step(0, 3'b100, dst(0, 0, 0), 3'b100, 3'b111, 3'b001, 2, 0, 0, 3'b100, 0, "t6_after");

        step(0, 3'b000, dst(0, 0, 0), 3'b000, 3'b111, 3'b000, 0, 0, 0, 3'b000, 0, "idle");
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || !stim_done) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0 (stim_done=%0b)", exp_q.size(),
                     stim_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
